// File: rtl/text_pkg.sv
// text_pkg: shared constants and FSM encoding for the 16x16 text buffer.
//   CODE_W / ADDR_W  : character code and {row, col} address widths
//   CHAR_*           : control and fill character codes
//   state_e          : buffer FSM states
//   is_printable()   : codes that are stored at the cursor
package text_pkg;

    localparam int unsigned COLS   = 16;
    localparam int unsigned ROWS   = 16;
    localparam int unsigned COL_W  = $clog2(COLS);
    localparam int unsigned ROW_W  = $clog2(ROWS);
    localparam int unsigned ADDR_W = ROW_W + COL_W;
    localparam int unsigned DEPTH  = COLS * ROWS;
    localparam int unsigned CODE_W = 7;

    localparam logic [CODE_W-1:0] CHAR_SPACE = 7'h20;
    localparam logic [CODE_W-1:0] CHAR_LF    = 7'h0A;
    localparam logic [CODE_W-1:0] CHAR_BS    = 7'h08;
    localparam logic [CODE_W-1:0] CHAR_FF    = 7'h0C;
    localparam logic [CODE_W-1:0] CHAR_CAN   = 7'h18;
    localparam logic [CODE_W-1:0] CHAR_TILDE = 7'h7E;

    typedef enum logic [1:0] {
        CLEAR  = 2'd0,
        IDLE   = 2'd1,
        ROWCLR = 2'd2
    } state_e;

    // 0x18 plus the visible ASCII range are written; everything else is control.
    function automatic logic is_printable(input logic [CODE_W-1:0] c);
        return (c == CHAR_CAN) || ((c >= CHAR_SPACE) && (c <= CHAR_TILDE));
    endfunction

endpackage

// File: rtl/text_buffer_16x16_if.sv
// text_buffer_16x16_if: character input, display read port and status.
//   master : drives char_in/char_valid/clear/char_xy (host side)
//   slave  : drives char_ready/char_code_out/cursor_xy/busy (buffer side)
interface text_buffer_16x16_if;
    import text_pkg::*;

    logic [CODE_W-1:0] char_in;
    logic              char_valid;
    logic              char_ready;
    logic              clear;
    logic [ADDR_W-1:0] char_xy;
    logic [CODE_W-1:0] char_code_out;
    logic [ADDR_W-1:0] cursor_xy;
    logic              busy;

    modport master (
        output char_in, char_valid, clear, char_xy,
        input  char_ready, char_code_out, cursor_xy, busy
    );

    modport slave (
        input  char_in, char_valid, clear, char_xy,
        output char_ready, char_code_out, cursor_xy, busy
    );

endinterface

// File: rtl/char_ram_256x7.sv
// char_ram_256x7: 256 x 7 character store, one write port, one read-first
// synchronous read port, contents not reset.
//   clk             : clock
//   we/waddr/wdata  : synchronous write
//   raddr/rdata     : registered read, returns pre-write data on collision
module char_ram_256x7
    import text_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [CODE_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [CODE_W-1:0] rdata
);

    logic [CODE_W-1:0] mem [DEPTH];

    // Read and write in one block so a same-address access sees old data.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/text_buffer_16x16.sv
// text_buffer_16x16: 16x16 character screen with a write cursor, line
// wrap, LF/BS/FF handling and full-screen / single-row blanking sweeps.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of text_buffer_16x16_if (char stream, display
//              read port, cursor position and busy status)
module text_buffer_16x16
    import text_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    text_buffer_16x16_if.slave   bus
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic              busy_q, busy_d;
    logic              force_sp_q, force_sp_d;

    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [CODE_W-1:0] ram_wdata;
    logic [CODE_W-1:0] ram_rdata;
    logic              ready;
    logic              handshake;
    logic [COL_W-1:0]  col_dec;

    assign ready     = (state_q == IDLE) && !bus.clear;
    assign handshake = bus.char_valid && ready;
    assign col_dec   = col_q - COL_W'(1);

    // Next-state, cursor, sweep counter and write-port decode.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        row_d     = row_q;
        col_d     = col_q;
        ram_we    = 1'b0;
        ram_waddr = {row_q, col_q};
        ram_wdata = CHAR_SPACE;

        case (state_q)
            CLEAR: begin
                ram_we    = 1'b1;
                ram_waddr = idx_q;
                idx_d     = idx_q + ADDR_W'(1);
                if (idx_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = IDLE;
                end
            end

            // Low idx bits sweep the columns of the (already advanced) cursor row.
            ROWCLR: begin
                ram_we    = 1'b1;
                ram_waddr = {row_q, idx_q[COL_W-1:0]};
                idx_d     = idx_q + ADDR_W'(1);
                if (idx_q[COL_W-1:0] == COL_W'(COLS - 1)) begin
                    state_d = IDLE;
                end
            end

            IDLE: begin
                if (handshake) begin
                    if (is_printable(bus.char_in)) begin
                        ram_we    = 1'b1;
                        ram_wdata = bus.char_in;
                        if (col_q == COL_W'(COLS - 1)) begin
                            col_d   = '0;
                            row_d   = row_q + ROW_W'(1);
                            idx_d   = '0;
                            state_d = ROWCLR;
                        end else begin
                            col_d = col_q + COL_W'(1);
                        end
                    end else if (bus.char_in == CHAR_LF) begin
                        col_d   = '0;
                        row_d   = row_q + ROW_W'(1);
                        idx_d   = '0;
                        state_d = ROWCLR;
                    end else if (bus.char_in == CHAR_BS) begin
                        if (col_q != '0) begin
                            col_d     = col_dec;
                            ram_we    = 1'b1;
                            ram_waddr = {row_q, col_dec};
                        end
                    end else if (bus.char_in == CHAR_FF) begin
                        row_d   = '0;
                        col_d   = '0;
                        idx_d   = '0;
                        state_d = CLEAR;
                    end
                end
            end

            default: begin
                idx_d   = '0;
                state_d = CLEAR;
            end
        endcase

        // clear wins over everything, restarting any sweep from cell 0.
        if (bus.clear) begin
            ram_we  = 1'b0;
            row_d   = '0;
            col_d   = '0;
            idx_d   = '0;
            state_d = CLEAR;
        end
    end

    // Registered status: busy tracks the next state, and the read pipe
    // remembers whether its sample was taken during a full clear.
    always_comb begin
        busy_d     = (state_d != IDLE);
        force_sp_d = (state_q == CLEAR);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= CLEAR;
            idx_q      <= '0;
            row_q      <= '0;
            col_q      <= '0;
            busy_q     <= 1'b1;
            force_sp_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            row_q      <= row_d;
            col_q      <= col_d;
            busy_q     <= busy_d;
            force_sp_q <= force_sp_d;
        end
    end

    char_ram_256x7 u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (bus.char_xy),
        .rdata (ram_rdata)
    );

    assign bus.char_ready    = ready;
    assign bus.busy          = busy_q;
    assign bus.cursor_xy     = {row_q, col_q};
    assign bus.char_code_out = force_sp_q ? CHAR_SPACE : ram_rdata;

endmodule
